// File: rtl/binary16_div_arbiter_if.sv
// Request/response and divider-side signal bundle for binary16_div_arbiter.
// slave = arbiter view, master = requesters plus divider view.
interface binary16_div_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0][15:0] req_a;
  logic [NUM_REQ-1:0][15:0] req_b;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [15:0]              resp_result;
  logic [15:0]              div_a;
  logic [15:0]              div_b;
  logic                     div_valid_in;
  logic [15:0]              div_result;
  logic                     div_valid_out;
  logic                     busy;

  modport slave (
    input  req_valid, req_a, req_b, div_result, div_valid_out,
    output req_ready, resp_valid, resp_result, div_a, div_b, div_valid_in, busy
  );

  modport master (
    output req_valid, req_a, req_b, div_result, div_valid_out,
    input  req_ready, resp_valid, resp_result, div_a, div_b, div_valid_in, busy
  );
endinterface

// File: rtl/binary16_div_arbiter.sv
// Round-robin sharing of one in-order pipelined binary16 divider among NUM_REQ requesters.
// Optional perf counters are enabled with the macro BINARY16_DIV_ARB_PERF_EN.
module binary16_div_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DIV_LATENCY = 25,
  parameter int unsigned TAG_DEPTH   = 32
) (
  input  logic                  clk_in,
  input  logic                  rst,
  binary16_div_arbiter_if.slave bus
`ifdef BINARY16_DIV_ARB_PERF_EN
  ,
  output logic [31:0]           perf_issued,
  output logic [31:0]           perf_stall
`endif
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned ADR_W = $clog2(TAG_DEPTH);
  localparam int unsigned PTR_W = ADR_W + 1;

  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]   tag_mem_q [TAG_DEPTH];
  logic               iss_valid_q, iss_valid_d;
  logic [15:0]        iss_a_q, iss_a_d;
  logic [15:0]        iss_b_q, iss_b_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [15:0]        resp_result_q, resp_result_d;
  logic               err_q, err_d;

  logic               empty_c;
  logic               full_c;
  logic               pop_c;
  logic               allow_c;
  logic               gnt_found_c;
  logic [IDX_W-1:0]   gnt_idx_c;
  logic [IDX_W-1:0]   cand_c;
  logic               xfer_c;
  logic [NUM_REQ-1:0] ready_c;
  logic [IDX_W-1:0]   head_c;

  // Tag FIFO status: extra pointer MSB distinguishes full from empty.
  always_comb begin
    empty_c = (wr_ptr_q == rd_ptr_q);
    full_c  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
              (wr_ptr_q[ADR_W-1:0] == rd_ptr_q[ADR_W-1:0]);
    pop_c   = bus.div_valid_out && !empty_c;
    head_c  = tag_mem_q[rd_ptr_q[ADR_W-1:0]];
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    allow_c = !full_c || pop_c;
  end

  // Round-robin search starting at rr_q.
  always_comb begin
    gnt_found_c = 1'b0;
    gnt_idx_c   = '0;
    cand_c      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_c = IDX_W'((32'(rr_q) + k) % NUM_REQ);
      if (!gnt_found_c && bus.req_valid[cand_c]) begin
        gnt_found_c = 1'b1;
        gnt_idx_c   = cand_c;
      end
    end
    xfer_c  = gnt_found_c && allow_c;
    ready_c = '0;
    if (xfer_c) begin
      ready_c[gnt_idx_c] = 1'b1;
    end
  end

  // Next-state for pointer, issue register, FIFO pointers and response register.
  always_comb begin
    rr_d          = rr_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    iss_valid_d   = xfer_c;
    iss_a_d       = iss_a_q;
    iss_b_d       = iss_b_q;
    resp_valid_d  = '0;
    resp_result_d = resp_result_q;
    err_d         = err_q || (bus.div_valid_out && empty_c);
    if (xfer_c) begin
      rr_d     = (gnt_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_c + IDX_W'(1);
      iss_a_d  = bus.req_a[gnt_idx_c];
      iss_b_d  = bus.req_b[gnt_idx_c];
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      resp_valid_d[head_c] = 1'b1;
      resp_result_d        = bus.div_result;
      rd_ptr_d             = rd_ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      rr_q          <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      iss_valid_q   <= 1'b0;
      iss_a_q       <= '0;
      iss_b_q       <= '0;
      resp_valid_q  <= '0;
      resp_result_q <= '0;
      err_q         <= 1'b0;
    end else begin
      rr_q          <= rr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      iss_valid_q   <= iss_valid_d;
      iss_a_q       <= iss_a_d;
      iss_b_q       <= iss_b_d;
      resp_valid_q  <= resp_valid_d;
      resp_result_q <= resp_result_d;
      err_q         <= err_d;
    end
  end

  // Tag storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk_in) begin
    if (xfer_c) begin
      tag_mem_q[wr_ptr_q[ADR_W-1:0]] <= gnt_idx_c;
    end
  end

  assign bus.req_ready    = rst ? '0 : ready_c;
  assign bus.div_valid_in = iss_valid_q;
  assign bus.div_a        = iss_a_q;
  assign bus.div_b        = iss_b_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_result  = resp_result_q;
  assign bus.busy         = iss_valid_q || !empty_c;

`ifdef BINARY16_DIV_ARB_PERF_EN
  logic [31:0] perf_issued_q, perf_issued_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_issued_d = perf_issued_q;
    perf_stall_d  = perf_stall_q;
    if (xfer_c) begin
      perf_issued_d = perf_issued_q + 32'd1;
    end
    if ((|bus.req_valid) && !xfer_c) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      perf_issued_q <= '0;
      perf_stall_q  <= '0;
    end else begin
      perf_issued_q <= perf_issued_d;
      perf_stall_q  <= perf_stall_d;
    end
  end

  assign perf_issued = perf_issued_q;
  assign perf_stall  = perf_stall_q;
`endif

  // Sizing sanity and the sticky orphan-result condition.
  a_cfg_ok: assert property (@(posedge clk_in)
    (NUM_REQ >= 2) && (NUM_REQ <= 8) && (TAG_DEPTH >= DIV_LATENCY + 1));
  a_no_orphan: assert property (@(posedge clk_in) disable iff (rst) !err_d);

endmodule

// File: tb/tb_binary16_div_arbiter.sv
// Directed bench for binary16_div_arbiter with behavioural power-of-two divider stubs.
module tb_binary16_div_arbiter;
  localparam int unsigned NR   = 4;
  localparam int unsigned LAT0 = 25;
  localparam int unsigned LAT1 = 40;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  binary16_div_arbiter_if #(.NUM_REQ(NR)) b0 ();
  binary16_div_arbiter_if #(.NUM_REQ(NR)) b1 ();

`ifdef BINARY16_DIV_ARB_PERF_EN
  logic [31:0] p0_iss, p0_stl, p1_iss, p1_stl;
`endif

  binary16_div_arbiter #(.NUM_REQ(NR), .DIV_LATENCY(LAT0), .TAG_DEPTH(32)) dut0 (
    .clk_in(clk), .rst(rst), .bus(b0)
`ifdef BINARY16_DIV_ARB_PERF_EN
    , .perf_issued(p0_iss), .perf_stall(p0_stl)
`endif
  );

  // FIFO sized for 15 cycles while the attached stub takes 40, forcing full.
  binary16_div_arbiter #(.NUM_REQ(NR), .DIV_LATENCY(15), .TAG_DEPTH(16)) dut1 (
    .clk_in(clk), .rst(rst), .bus(b1)
`ifdef BINARY16_DIV_ARB_PERF_EN
    , .perf_issued(p1_iss), .perf_stall(p1_stl)
`endif
  );

  function automatic logic [15:0] p2div(input logic [15:0] a, input logic [15:0] b);
    logic [5:0] e;
    e = 6'(a[14:10]) - 6'(b[14:10]) + 6'd15;
    return {a[15] ^ b[15], e[4:0], 10'd0};
  endfunction

  logic [LAT0-1:0] s0_v;
  logic [15:0]     s0_r [LAT0];
  logic [LAT1-1:0] s1_v;
  logic [15:0]     s1_r [LAT1];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_v <= '0;
      s1_v <= '0;
      for (int i = 0; i < int'(LAT0); i++) s0_r[i] <= '0;
      for (int i = 0; i < int'(LAT1); i++) s1_r[i] <= '0;
    end else begin
      s0_v    <= {s0_v[LAT0-2:0], b0.div_valid_in};
      s1_v    <= {s1_v[LAT1-2:0], b1.div_valid_in};
      s0_r[0] <= p2div(b0.div_a, b0.div_b);
      s1_r[0] <= p2div(b1.div_a, b1.div_b);
      for (int i = 1; i < int'(LAT0); i++) s0_r[i] <= s0_r[i-1];
      for (int i = 1; i < int'(LAT1); i++) s1_r[i] <= s1_r[i-1];
    end
  end

  assign b0.div_valid_out = s0_v[LAT0-1];
  assign b0.div_result    = s0_r[LAT0-1];
  assign b1.div_valid_out = s1_v[LAT1-1];
  assign b1.div_result    = s1_r[LAT1-1];

  int          g0[$];
  int          gc0[$];
  logic [3:0]  rv0[$];
  logic [15:0] rr0[$];
  int          rc0[$];
  int          vin0 = 0;
  int          gc1[$];
  logic [3:0]  rv1[$];
  logic [15:0] rr1[$];

  // Transaction monitor, sampled on the falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < int'(NR); i++) begin
      if (b0.req_valid[i] && b0.req_ready[i]) begin
        g0.push_back(i);
        gc0.push_back(cyc);
      end
      if (b1.req_valid[i] && b1.req_ready[i]) gc1.push_back(cyc);
    end
    if (|b0.resp_valid) begin
      rv0.push_back(b0.resp_valid);
      rr0.push_back(b0.resp_result);
      rc0.push_back(cyc);
    end
    if (|b1.resp_valid) begin
      rv1.push_back(b1.resp_valid);
      rr1.push_back(b1.resp_result);
    end
    if (b0.div_valid_in) vin0 = vin0 + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
  endtask

  logic [15:0] t3_b   [10] = '{16'h4000, 16'h4400, 16'h3800, 16'h3C00, 16'h4800,
                               16'h3400, 16'h4C00, 16'h3000, 16'h5000, 16'h2C00};
  logic [15:0] t3_exp [10] = '{16'h3800, 16'h3400, 16'h4000, 16'h3C00, 16'h3000,
                               16'h4400, 16'h2C00, 16'h4800, 16'h2800, 16'h4C00};

  initial begin
    int gb, rb, vb, rb1;
    rst          = 1'b1;
    b0.req_valid = '0;
    b0.req_a     = '0;
    b0.req_b     = '0;
    b1.req_valid = '0;
    b1.req_a     = '0;
    b1.req_b     = '0;
    repeat (3) step();

    // Reset state, with requests pending to prove req_ready is held low.
    b0.req_valid = 4'hF;
    #1;
    chk("rst_req_ready", 32'(b0.req_ready), 32'h0);
    chk("rst_resp_valid", 32'(b0.resp_valid), 32'h0);
    chk("rst_resp_result", 32'(b0.resp_result), 32'h0);
    chk("rst_div_valid_in", 32'(b0.div_valid_in), 32'h0);
    chk("rst_div_a", 32'(b0.div_a), 32'h0);
    chk("rst_div_b", 32'(b0.div_b), 32'h0);
    chk("rst_busy", 32'(b0.busy), 32'h0);
    b0.req_valid = '0;
    rst = 1'b0;
    step();

    // Single op: 4.0 / 2.0 from requester 0.
    gb = g0.size();
    rb = rv0.size();
    b0.req_a[0]  = 16'h4400;
    b0.req_b[0]  = 16'h4000;
    b0.req_valid = 4'b0001;
    #1;
    chk("t1_ready", 32'(b0.req_ready), 32'h1);
    step();
    b0.req_valid = '0;
    chk("t1_div_valid_in", 32'(b0.div_valid_in), 32'h1);
    chk("t1_div_a", 32'(b0.div_a), 32'h4400);
    chk("t1_div_b", 32'(b0.div_b), 32'h4000);
    chk("t1_busy", 32'(b0.busy), 32'h1);
    for (int k = 0; k < 40 && rv0.size() == rb; k++) step();
    chk("t1_resp_count", 32'(rv0.size() - rb), 32'h1);
    if (rv0.size() > rb && g0.size() > gb) begin
      chk("t1_resp_valid", 32'(rv0[rb]), 32'h1);
      chk("t1_resp_result", 32'(rr0[rb]), 32'h4000);
      chk("t1_latency", 32'(rc0[rb] - gc0[gb]), 32'd27);
    end
    step();
    chk("t1_idle_busy", 32'(b0.busy), 32'h0);

    // All four requesters valid: strict rotation, one issue per cycle.
    pulse_reset();
    gb = g0.size();
    rb = rv0.size();
    vb = vin0;
    for (int i = 0; i < int'(NR); i++) begin
      b0.req_a[i] = 16'h3C00;
      b0.req_b[i] = 16'h4000;
    end
    b0.req_valid = 4'hF;
    repeat (12) step();
    b0.req_valid = '0;
    repeat (40) step();
    chk("t2_grant_count", 32'(g0.size() - gb), 32'd12);
    chk("t2_resp_count", 32'(rv0.size() - rb), 32'd12);
    chk("t2_div_valid_cycles", 32'(vin0 - vb), 32'd12);
    if (g0.size() - gb >= 12 && rv0.size() - rb >= 12) begin
      chk("t2_back_to_back", 32'(gc0[gb+11] - gc0[gb]), 32'd11);
      for (int i = 0; i < 12; i++) begin
        chk($sformatf("t2_grant%0d", i), 32'(g0[gb+i]), 32'(i % 4));
        chk($sformatf("t2_route%0d", i), 32'(rv0[rb+i]), 32'(4'b0001 << (i % 4)));
        chk($sformatf("t2_result%0d", i), 32'(rr0[rb+i]), 32'h3800);
      end
    end

    // Only requester 2 valid: consecutive grants, in-order results.
    pulse_reset();
    gb = g0.size();
    rb = rv0.size();
    for (int k = 0; k < 10; k++) begin
      b0.req_a[2]  = 16'h3C00;
      b0.req_b[2]  = t3_b[k];
      b0.req_valid = 4'b0100;
      step();
    end
    b0.req_valid = '0;
    repeat (40) step();
    chk("t3_grant_count", 32'(g0.size() - gb), 32'd10);
    chk("t3_resp_count", 32'(rv0.size() - rb), 32'd10);
    if (g0.size() - gb >= 10 && rv0.size() - rb >= 10) begin
      chk("t3_back_to_back", 32'(gc0[gb+9] - gc0[gb]), 32'd9);
      for (int k = 0; k < 10; k++) begin
        chk($sformatf("t3_grant%0d", k), 32'(g0[gb+k]), 32'd2);
        chk($sformatf("t3_route%0d", k), 32'(rv0[rb+k]), 32'h4);
        chk($sformatf("t3_result%0d", k), 32'(rr0[rb+k]), 32'(t3_exp[k]));
      end
    end

    // Tag FIFO full on the 16-deep instance with a 40-cycle divider.
    pulse_reset();
    gb  = gc1.size();
    rb1 = rv1.size();
    b1.req_a[0]  = 16'h3C00;
    b1.req_b[0]  = 16'h4000;
    b1.req_valid = 4'b0001;
    for (int k = 0; k < 100; k++) begin
      step();
      if (k == 20) chk("t4_full_ready", 32'(b1.req_ready), 32'h0);
      if (gc1.size() - gb >= 20) break;
    end
    b1.req_valid = '0;
    chk("t4_grant_count", 32'(gc1.size() - gb), 32'd20);
    if (gc1.size() - gb >= 20) begin
      chk("t4_first_burst", 32'(gc1[gb+15] - gc1[gb]), 32'd15);
      chk("t4_resume", 32'(gc1[gb+16] - gc1[gb]), 32'd41);
      chk("t4_tail", 32'(gc1[gb+19] - gc1[gb+16]), 32'd3);
    end
`ifdef BINARY16_DIV_ARB_PERF_EN
    chk("perf_issued", p1_iss, 32'd20);
    chk("perf_stall", p1_stl, 32'd25);
`endif
    repeat (60) step();
    chk("t4_resp_count", 32'(rv1.size() - rb1), 32'd20);
    if (rv1.size() - rb1 >= 20) begin
      for (int k = 0; k < 20; k++) begin
        chk($sformatf("t4_route%0d", k), 32'(rv1[rb1+k]), 32'h1);
        chk($sformatf("t4_result%0d", k), 32'(rr1[rb1+k]), 32'h3800);
      end
    end
    chk("t4_idle_busy", 32'(b1.busy), 32'h0);

    // Asynchronous reset with 20 operations in flight.
    pulse_reset();
    rb = rv0.size();
    for (int i = 0; i < int'(NR); i++) begin
      b0.req_a[i] = 16'h3C00;
      b0.req_b[i] = 16'h4000;
    end
    b0.req_valid = 4'hF;
    repeat (20) step();
    chk("t5_busy_before", 32'(b0.busy), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_req_ready", 32'(b0.req_ready), 32'h0);
    chk("t5_rst_div_valid_in", 32'(b0.div_valid_in), 32'h0);
    chk("t5_rst_div_a", 32'(b0.div_a), 32'h0);
    chk("t5_rst_resp_valid", 32'(b0.resp_valid), 32'h0);
    chk("t5_rst_busy", 32'(b0.busy), 32'h0);
    b0.req_valid = '0;
    step();
    step();
    rst = 1'b0;
    repeat (60) step();
    chk("t5_no_stale_resp", 32'(rv0.size() - rb), 32'h0);
    rb = rv0.size();
    b0.req_a[3]  = 16'h4400;
    b0.req_b[3]  = 16'h3C00;
    b0.req_valid = 4'b1000;
    step();
    b0.req_valid = '0;
    for (int k = 0; k < 40 && rv0.size() == rb; k++) step();
    chk("t5_new_resp_count", 32'(rv0.size() - rb), 32'h1);
    if (rv0.size() > rb) begin
      chk("t5_new_route", 32'(rv0[rb]), 32'h8);
      chk("t5_new_result", 32'(rr0[rb]), 32'h4400);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
